sprite_plotter: RTL and testbench
=================================

Name: sprite_plotter

Overview:
- Downstream drawing stage. Consumes a sprite position (x from the fixed column, y from the ping-pong buffer read path) and emits one pixel write per clock to the VGA adapter's write port (x, y, colour, plot).
- On each redraw request it erases the sprite at its previous position with the background colour, then draws it at the new position.
- The sprite shape is a right-triangle mask.
- One redraw is requested per position update.

Parameters:
- SPRITE_W, 8, sprite width in pixels (1..16)
- SPRITE_H, 8, sprite height in pixels (1..16)
- SCREEN_W, 320, visible columns; pixels with x >= SCREEN_W are clipped
- SCREEN_H, 240, visible rows; pixels with y >= SCREEN_H are clipped
- BG_COLOUR, 3'b000, colour used for erase

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  single-cycle redraw request, sampled in IDLE only
- new_x  in  9  new sprite top-left column
- new_y  in  8  new sprite top-left row
- fg_colour  in  3  sprite colour, latched with start
- ox  out  9  pixel column to adapter
- oy  out  8  pixel row to adapter
- colour  out  3  pixel colour to adapter
- plot  out  1  pixel write strobe
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse at end of redraw

Behaviour:
- Reset (async, immediate): state=IDLE; ox=0, oy=0, colour=0, plot=0, busy=0, done=0; old_valid=0; old_x=0, old_y=0; cx=cy=0.
- All outputs are registered.
- States: IDLE, ERASE, DRAW, DONE.
- IDLE, start=1:
  - latch new_x, new_y, fg_colour; clear cx, cy.
  - Go to ERASE if old_valid=1 and (old_x,old_y) != (new_x,new_y); otherwise go to DRAW.
- Scan order: row-major, cx 0..SPRITE_W-1 inner, cy 0..SPRITE_H-1 outer. One pixel per clock, no stalls.
- Pixel address: px = base_x + cx, py = base_y + cy. Compute at 10/9 bits, with no wrap.
- plot=1 for a pixel only when all hold:
  - cx <= cy * SPRITE_W / SPRITE_H (triangle mask; with W=H this is cx <= cy)
  - px < SCREEN_W
  - py < SCREEN_H
- Clipped and masked pixels still consume their cycle, with plot=0. ox/oy/colour still show the truncated address.
- ERASE: base = old position, colour = BG_COLOUR. After the last pixel (cx=W-1, cy=H-1), go to DRAW with cx=cy=0.
- DRAW: base = latched new position, colour = latched fg_colour. After the last pixel, update old_x/old_y with the new position, set old_valid=1, and go to DONE.
- DONE: plot=0, done=1 for exactly one cycle, then IDLE. busy is still 1 in DONE.
- Latency (W=H=8, erase needed):
  - start sampled at edge 0; first erase pixel is visible after edge 1.
  - Erase occupies 64 cycles and draw occupies 64 cycles.
  - done is high in the cycle after the 128th pixel.
  - busy falls together with done's fall.
- Latency without erase: done follows 64 draw cycles.
- start while busy (including in the DONE cycle) is ignored and not queued.
- Input changes on new_x, new_y or fg_colour during busy have no effect.
- Reset mid-operation aborts immediately. old_valid=0, so the next redraw skips erase. Stale pixels left on screen are acceptable.

Decomposition:
- Shared package (vga_pkg) holds:
  - state encoding localparams (IDLE/ERASE/DRAW/DONE)
  - SCREEN_W/SCREEN_H defaults
  - colour constants (BLACK, WHITE, etc.)
- One natural sub-module, sprite_scan_counter: cx/cy counter with clear/enable and a `last` flag.
- Mask, clip and FSM stay in sprite_plotter.

Test Plan:
- Reset, then start with new_x=114, new_y=20, fg=3'b111: no erase. Require:
  - exactly 36 plot pulses, all colour=7, within x 114..121 and y 20..27.
  - first plot at (114,20); done at cycle 65; busy high cycles 1..65.
- Then start with new_x=114, new_y=30: require 36 plots with colour=0 at y 20..27, then 36 plots with colour=7 at y 30..37, and done at cycle 129.
- Start again at the same position (114,30): erase is skipped, 36 plots, done at cycle 65.
- Clipping: start with new_x=316, new_y=236. Require plot=0 whenever ox>=320 or oy>=240, and the number of plotted pixels equals the mask count inside the screen (10).
- Assert start at mid-draw (cycle 30) and in the DONE cycle: no effect, and the pixel count is unchanged.
- Assert reset at cycle 40 of a draw:
  - all outputs are 0 immediately (asynchronous).
  - the next start performs a draw only (36 plots), with no erase.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared constants for the VGA drawing path: FSM encodings, screen defaults,
// the 3-bit colour palette and the sprite mask helper.
package vga_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ERASE = 2'd1;
  localparam logic [1:0] ST_DRAW  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam int unsigned SCREEN_W_DEF = 320;
  localparam int unsigned SCREEN_H_DEF = 240;

  localparam logic [2:0] BLACK   = 3'b000;
  localparam logic [2:0] BLUE    = 3'b001;
  localparam logic [2:0] GREEN   = 3'b010;
  localparam logic [2:0] CYAN    = 3'b011;
  localparam logic [2:0] RED     = 3'b100;
  localparam logic [2:0] MAGENTA = 3'b101;
  localparam logic [2:0] YELLOW  = 3'b110;
  localparam logic [2:0] WHITE   = 3'b111;

  // Right-triangle mask: cx <= cy*w/h, evaluated as cx*h <= cy*w to avoid division.
  function automatic logic in_mask(input logic [3:0] cx, input logic [3:0] cy,
                                   input int unsigned w, input int unsigned h);
    return (32'(cx) * h) <= (32'(cy) * w);
  endfunction

endpackage

// File: rtl/sprite_plotter_if.sv
// Redraw request and pixel write port between the plotter and the VGA adapter.
interface sprite_plotter_if;
  logic       start;
  logic [8:0] new_x;
  logic [7:0] new_y;
  logic [2:0] fg_colour;
  logic [8:0] ox;
  logic [7:0] oy;
  logic [2:0] colour;
  logic       plot;
  logic       busy;
  logic       done;

  modport master (
    input  start, new_x, new_y, fg_colour,
    output ox, oy, colour, plot, busy, done
  );

  modport slave (
    output start, new_x, new_y, fg_colour,
    input  ox, oy, colour, plot, busy, done
  );
endinterface

// File: rtl/sprite_scan_counter.sv
// Row-major cx/cy scan over the sprite bounding box with clear/enable and a last flag.
module sprite_scan_counter #(
  parameter int unsigned SPRITE_W = 8,
  parameter int unsigned SPRITE_H = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       en,
  output logic [3:0] cx,
  output logic [3:0] cy,
  output logic       last
);
  localparam logic [3:0] CX_MAX = 4'(SPRITE_W - 1);
  localparam logic [3:0] CY_MAX = 4'(SPRITE_H - 1);

  assign last = (cx == CX_MAX) && (cy == CY_MAX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cx <= '0;
      cy <= '0;
    end else if (clear) begin
      cx <= '0;
      cy <= '0;
    end else if (en) begin
      if (cx == CX_MAX) begin
        cx <= '0;
        cy <= (cy == CY_MAX) ? '0 : cy + 4'd1;
      end else begin
        cx <= cx + 4'd1;
      end
    end
  end
endmodule

// File: rtl/sprite_plotter.sv
// Erase-then-draw sprite plotter: one registered pixel write per clock to the VGA adapter.
module sprite_plotter
  import vga_pkg::*;
#(
  parameter int unsigned SPRITE_W  = 8,
  parameter int unsigned SPRITE_H  = 8,
  parameter int unsigned SCREEN_W  = SCREEN_W_DEF,
  parameter int unsigned SCREEN_H  = SCREEN_H_DEF,
  parameter logic [2:0]  BG_COLOUR = BLACK
) (
  input logic              clk,
  input logic              reset,
  sprite_plotter_if.master bus
);
  logic [1:0] state;
  logic [8:0] old_x, lat_x, ox_q, base_x;
  logic [7:0] old_y, lat_y, oy_q, base_y;
  logic [2:0] lat_fg, colour_q, pix_colour;
  logic       old_valid, plot_q, busy_q, done_q;
  logic [3:0] cx, cy;
  logic       last, scan_clear, scan_en;
  logic [9:0] px;
  logic [8:0] py;
  logic       pix_vis, need_erase, accept;

  sprite_scan_counter #(.SPRITE_W(SPRITE_W), .SPRITE_H(SPRITE_H)) u_scan (
    .clk  (clk),
    .reset(reset),
    .clear(scan_clear),
    .en   (scan_en),
    .cx   (cx),
    .cy   (cy),
    .last (last)
  );

  always_comb begin
    scan_en    = (state == ST_ERASE) || (state == ST_DRAW);
    scan_clear = (state == ST_IDLE) || ((state == ST_ERASE) && last);
    need_erase = old_valid && ((old_x != bus.new_x) || (old_y != bus.new_y));
    // busy_q still high marks the done cycle, so a start there is dropped.
    accept     = (state == ST_IDLE) && bus.start && !busy_q;
    base_x     = (state == ST_ERASE) ? old_x : lat_x;
    base_y     = (state == ST_ERASE) ? old_y : lat_y;
    pix_colour = (state == ST_ERASE) ? BG_COLOUR : lat_fg;
    px         = 10'(base_x) + 10'(cx);
    py         = 9'(base_y) + 9'(cy);
    pix_vis    = in_mask(cx, cy, SPRITE_W, SPRITE_H) &&
                 (px < 10'(SCREEN_W)) && (py < 9'(SCREEN_H));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      ox_q      <= '0;
      oy_q      <= '0;
      colour_q  <= '0;
      plot_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      old_valid <= 1'b0;
      old_x     <= '0;
      old_y     <= '0;
      lat_x     <= '0;
      lat_y     <= '0;
      lat_fg    <= '0;
    end else begin
      busy_q <= (state != ST_IDLE);
      done_q <= 1'b0;
      plot_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            lat_x  <= bus.new_x;
            lat_y  <= bus.new_y;
            lat_fg <= bus.fg_colour;
            state  <= need_erase ? ST_ERASE : ST_DRAW;
          end
        end
        ST_ERASE, ST_DRAW: begin
          ox_q     <= px[8:0];
          oy_q     <= py[7:0];
          colour_q <= pix_colour;
          plot_q   <= pix_vis;
          if (last) begin
            if (state == ST_ERASE) begin
              state <= ST_DRAW;
            end else begin
              old_x     <= lat_x;
              old_y     <= lat_y;
              old_valid <= 1'b1;
              state     <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          done_q <= 1'b1;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.ox     = ox_q;
  assign bus.oy     = oy_q;
  assign bus.colour = colour_q;
  assign bus.plot   = plot_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
endmodule

// File: tb/tb_sprite_plotter.sv
// Scoreboard bench for sprite_plotter: expected pixel stream queued at start, compared per cycle.
module tb_sprite_plotter;
  logic clk = 1'b0;
  logic reset = 1'b1;

  sprite_plotter_if bus();

  sprite_plotter #(
    .SPRITE_W (8),
    .SPRITE_H (8),
    .SCREEN_W (320),
    .SCREEN_H (240),
    .BG_COLOUR(3'b000)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [8:0] x;
    logic [7:0] y;
    logic [2:0] fg;
    int         plots;
    int         done_cyc;
  } vec_t;

  int tests = 0;
  int fails = 0;
  logic [20:0] sb[$];
  bit         m_old_valid = 1'b0;
  int         m_old_x = 0;
  int         m_old_y = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_scan(input int bx, input int by, input logic [2:0] col);
    for (int cy = 0; cy < 8; cy++) begin
      for (int cx = 0; cx < 8; cx++) begin
        int px, py;
        logic p;
        logic [8:0] ax;
        logic [7:0] ay;
        px = bx + cx;
        py = by + cy;
        p  = (cx <= cy) && (px < 320) && (py < 240);
        ax = px[8:0];
        ay = py[7:0];
        sb.push_back({ax, ay, col, p});
      end
    end
  endtask

  task automatic check_idle_outputs(input string name);
    check(name, 32'({bus.ox, bus.oy, bus.colour, bus.plot, bus.busy, bus.done}), 32'd0);
  endtask

  task automatic run_redraw(input string nm, input logic [8:0] x, input logic [7:0] y,
                            input logic [2:0] fg, input int exp_plots, input int exp_done,
                            input int inj_cyc, input bit inj_done, input int abort_cyc);
    int n_pix, plots, done_cyc;
    bit erase;
    logic [20:0] exp;
    erase = m_old_valid && ((m_old_x != int'(x)) || (m_old_y != int'(y)));
    if (erase) push_scan(m_old_x, m_old_y, 3'b000);
    push_scan(int'(x), int'(y), fg);
    n_pix = sb.size();

    @(negedge clk);
    bus.start = 1'b1; bus.new_x = x; bus.new_y = y; bus.fg_colour = fg;
    @(posedge clk); #1;
    bus.start = 1'b0;

    plots = 0;
    done_cyc = -1;
    for (int n = 1; n <= n_pix + 4 && done_cyc < 0; n++) begin
      @(posedge clk); #1;
      bus.start = 1'b0;
      if (n == abort_cyc) begin
        #2 reset = 1'b1;
        #1 check_idle_outputs({nm, " async reset"});
        sb.delete();
        m_old_valid = 1'b0;
        #2 reset = 1'b0;
        return;
      end
      if (sb.size() > 0) begin
        exp = sb.pop_front();
        check({nm, " pixel"}, 32'({bus.ox, bus.oy, bus.colour, bus.plot}), 32'(exp));
        check({nm, " busy"}, 32'({bus.busy, bus.done}), 32'b10);
        if (bus.plot) plots++;
      end else if (bus.done) begin
        done_cyc = n;
        check({nm, " done cycle outputs"}, 32'({bus.busy, bus.plot}), 32'b10);
        if (inj_done) bus.start = 1'b1;
      end
      if (n == inj_cyc) begin
        bus.start = 1'b1;
        bus.new_x = 9'($urandom_range(0, 511));
        bus.new_y = 8'($urandom_range(0, 255));
        bus.fg_colour = 3'($urandom_range(0, 7));
      end
    end
    check({nm, " done cycle"}, 32'(done_cyc), 32'(exp_done));
    check({nm, " plot count"}, 32'(plots), 32'(exp_plots));

    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      bus.start = 1'b0;
      check({nm, " after done"}, 32'({bus.busy, bus.done, bus.plot}), 32'd0);
    end
    sb.delete();
    m_old_valid = 1'b1;
    m_old_x = int'(x);
    m_old_y = int'(y);
  endtask

  vec_t vecs[4];

  initial begin
    vecs[0] = '{x: 9'd114, y: 8'd20,  fg: 3'b111, plots: 36, done_cyc: 65};
    vecs[1] = '{x: 9'd114, y: 8'd30,  fg: 3'b111, plots: 72, done_cyc: 129};
    vecs[2] = '{x: 9'd114, y: 8'd30,  fg: 3'b111, plots: 36, done_cyc: 65};
    vecs[3] = '{x: 9'd316, y: 8'd236, fg: 3'b101, plots: 46, done_cyc: 129};

    bus.start = 1'b0;
    bus.new_x = '0;
    bus.new_y = '0;
    bus.fg_colour = '0;
    #12 check_idle_outputs("reset state");
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    check_idle_outputs("post-reset idle");

    foreach (vecs[i])
      run_redraw($sformatf("vec%0d", i), vecs[i].x, vecs[i].y, vecs[i].fg,
                 vecs[i].plots, vecs[i].done_cyc, -1, 1'b0, -1);

    // erase of the clipped sprite plots 10, draw plots 36; stray starts ignored
    run_redraw("ignored starts", 9'd50, 8'd60, 3'b011, 46, 129, 30, 1'b1, -1);

    // same position: no erase, abort mid-draw
    run_redraw("abort", 9'd50, 8'd60, 3'b010, 36, 65, -1, 1'b0, 40);
    @(posedge clk); #1;
    check_idle_outputs("idle after abort");

    run_redraw("post-abort", 9'd200, 8'd100, 3'b110, 36, 65, -1, 1'b0, -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
